// File: rtl/line_packer.sv
// Packs WORD_W-bit words into WORD_W*WORDS-bit lines and issues one single-cycle Memory write per line.
// `LINE_PACKER_FLUSH_PAD_EN: a flush writes the partial line zero-padded; otherwise it is discarded.
module line_packer #(
    parameter int WORD_W    = 32,
    parameter int WORDS     = 16,
    parameter int ADDR_W    = 9,
    parameter int ADDR_STEP = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [WORD_W-1:0]         in_data_i,
    input  logic                      flush_i,
    output logic [ADDR_W-1:0]         mem_address_o,
    output logic                      mem_we_o,
    output logic                      mem_oe_o,
    output logic [WORD_W*WORDS-1:0]   mem_din_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [7:0]                line_count_o
);

    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [KW-1:0]           k_q, k_d, k_next;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [WORD_W*WORDS-1:0] din_q, din_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    done_q, done_d;
    // Set when the pending WRITE must end the run (flush arrived with it).
    logic                    last_q, last_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        k_next  = k_q;
        addr_d  = addr_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FILL;
                    addr_d  = base_addr_i;
                    k_d     = '0;
                    din_d   = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
            S_FILL: begin
                if (start_i) begin
                    addr_d = base_addr_i;
                    k_d    = '0;
                    din_d  = '0;
                    cnt_d  = '0;
                    last_d = 1'b0;
                end else begin
                    if (in_valid_i) begin
                        din_d[int'(k_q)*WORD_W +: WORD_W] = in_data_i;
                        k_next = k_q + 1'b1;
                    end
                    k_d = k_next;
                    if (in_valid_i && k_q == KW'(WORDS-1)) begin
                        state_d = S_WRITE;
                        k_d     = '0;
                        last_d  = flush_i;
                    end else if (flush_i) begin
`ifdef LINE_PACKER_FLUSH_PAD_EN
                        if (k_next != '0) begin
                            state_d = S_WRITE;
                            last_d  = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        k_d     = '0;
                        din_d   = '0;
`endif
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(ADDR_STEP);
                cnt_d  = cnt_q + 8'd1;
                k_d    = '0;
                din_d  = '0;
                last_d = 1'b0;
                if (last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign in_ready_o    = (state_q == S_FILL);
    assign mem_we_o      = (state_q == S_WRITE);
    assign mem_oe_o      = (state_q != S_WRITE);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign mem_address_o = addr_q;
    assign mem_din_o     = din_q;
    assign line_count_o  = cnt_q;

endmodule

// File: tb/tb_line_packer.sv
// Randomized self-checking bench for line_packer against a queue-based line model.
module tb_line_packer;
    localparam int WORD_W = 32;
    localparam int WORDS  = 16;
    localparam int ADDR_W = 9;
    localparam int STEP   = 16;
    localparam int LW     = WORD_W*WORDS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              flush;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_we;
    logic              mem_oe;
    logic [LW-1:0]     mem_din;
    logic              busy;
    logic              done;
    logic [7:0]        line_count;

    line_packer #(.WORD_W(WORD_W), .WORDS(WORDS), .ADDR_W(ADDR_W), .ADDR_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base_addr),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .flush_i(flush),
        .mem_address_o(mem_address), .mem_we_o(mem_we), .mem_oe_o(mem_oe), .mem_din_o(mem_din),
        .busy_o(busy), .done_o(done), .line_count_o(line_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int we_cyc, stall_cyc;
    logic [ADDR_W-1:0] got_addr[$], exp_addr[$];
    logic [LW-1:0]     got_dat[$],  exp_dat[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_address);
            got_dat.push_back(mem_din);
            we_cyc++;
        end
        if (busy === 1'b1 && in_ready === 1'b0) stall_cyc++;
    end

    // Reference model: a line buffer filled word by word, flushed to the expected queue.
    logic [ADDR_W-1:0] m_addr;
    logic [LW-1:0]     m_line;
    int                m_k, m_cnt;

    task automatic m_start(input logic [ADDR_W-1:0] b);
        m_addr = b; m_line = '0; m_k = 0; m_cnt = 0;
    endtask

    task automatic m_emit();
        exp_addr.push_back(m_addr);
        exp_dat.push_back(m_line);
        m_addr = ADDR_W'((int'(m_addr) + STEP) % (1 << ADDR_W));
        m_cnt  = (m_cnt + 1) % 256;
        m_k = 0; m_line = '0;
    endtask

    task automatic m_word(input logic [WORD_W-1:0] w);
        m_line[m_k*WORD_W +: WORD_W] = w;
        m_k++;
        if (m_k == WORDS) m_emit();
    endtask

    task automatic m_flush();
`ifdef LINE_PACKER_FLUSH_PAD_EN
        if (m_k > 0) m_emit();
`endif
        m_k = 0; m_line = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        got_addr.delete(); got_dat.delete(); exp_addr.delete(); exp_dat.delete();
        we_cyc = 0; stall_cyc = 0;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        start = 1'b1; base_addr = b; in_valid = 1'b0; flush = 1'b0;
        step();
        start = 1'b0;
        m_start(b);
    endtask

    task automatic send(input int n, input logic [WORD_W-1:0] first, input bit rnd);
        int acc_n = 0;
        int guard = 0;
        bit acc;
        while (acc_n < n && guard < n*4 + 40) begin
            in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = rnd ? $urandom : first + WORD_W'(acc_n);
            acc = in_valid && in_ready;
            step();
            if (acc) begin m_word(in_data); acc_n++; end
            guard++;
        end
        in_valid = 1'b0;
        total++;
        if (acc_n != n) begin bad++; $display("FAIL send_words accepted=%0d required=%0d", acc_n, n); end
    endtask

    task automatic do_flush(input bit with_word);
        bit acc;
        int g = 0;
        while (!in_ready && g < 5) begin step(); g++; end
        flush = 1'b1; in_valid = with_word; in_data = $urandom;
        acc = in_valid && in_ready;
        step();
        if (acc) m_word(in_data);
        flush = 1'b0; in_valid = 1'b0;
        m_flush();
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (done) seen = 1'b1; else step();
        end
        total++;
        if (!seen) begin bad++; $display("FAIL %s_done_pulse got=0 required=1", tag); end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s_after_done done=%b busy=%b required done=0 busy=0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        step(); step();
        total++;
        if ({in_ready, mem_we, mem_oe, busy, done} !== 5'b00100) begin
            bad++; $display("FAIL reset_ctrl got=%b required=00100", {in_ready, mem_we, mem_oe, busy, done});
        end
        total++;
        if (mem_address !== '0 || mem_din !== '0 || line_count !== 8'd0) begin
            bad++; $display("FAIL reset_data addr=%0d cnt=%0d din_nonzero=%b required 0 0 0", mem_address, line_count, |mem_din);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_two_lines();
        clear_logs();
        do_start(9'd0);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL two_ready_after_start got=%b required=1", in_ready); end
        send(32, 32'h1000, 1'b0);
        step(); step(); step();
        total++;
        if (got_addr.size() != exp_addr.size()) begin
            bad++; $display("FAIL two_write_count got=%0d required=%0d", got_addr.size(), exp_addr.size());
        end else foreach (exp_addr[i]) begin
            total++;
            if (got_addr[i] !== exp_addr[i] || got_dat[i] !== exp_dat[i]) begin
                bad++; $display("FAIL two_line%0d addr=%0d data=%h required addr=%0d data=%h", i, got_addr[i], got_dat[i], exp_addr[i], exp_dat[i]);
            end
        end
        if (got_addr.size() == 2) begin
            total++;
            if (got_dat[0][31:0] !== 32'h1000 || got_dat[1][511:480] !== 32'h101F || got_addr[1] !== 9'd16) begin
                bad++; $display("FAIL two_fixed w0=%h w31=%h addr1=%0d required 1000 101f 16", got_dat[0][31:0], got_dat[1][511:480], got_addr[1]);
            end
        end
        total++;
        if (we_cyc != 2 || stall_cyc != 2 || line_count !== 8'd2) begin
            bad++; $display("FAIL two_timing we=%0d stall=%0d cnt=%0d required 2 2 2", we_cyc, stall_cyc, line_count);
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        do_start(9'd496);
        send(48, '0, 1'b1);
        step(); step(); step();
        total++;
        if (got_addr.size() != 3) begin
            bad++; $display("FAIL wrap_write_count got=%0d required=3", got_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                total++;
                if (got_addr[i] !== exp_addr[i] || got_dat[i] !== exp_dat[i]) begin
                    bad++; $display("FAIL wrap_line%0d addr=%0d required=%0d data_ok=%b", i, got_addr[i], exp_addr[i], got_dat[i] === exp_dat[i]);
                end
            end
            total++;
            if (got_addr[0] !== 9'd496 || got_addr[1] !== 9'd0 || got_addr[2] !== 9'd16) begin
                bad++; $display("FAIL wrap_addrs got=%0d,%0d,%0d required=496,0,16", got_addr[0], got_addr[1], got_addr[2]);
            end
        end
        total++;
        if (line_count !== 8'd3) begin bad++; $display("FAIL wrap_count got=%0d required=3", line_count); end
    endtask

    task automatic test_flush();
        clear_logs();
        do_start(9'd32);
        send(5, 32'hA0, 1'b0);
        do_flush(1'b0);
        wait_done("flush");
        step();
`ifdef LINE_PACKER_FLUSH_PAD_EN
        total++;
        if (got_addr.size() != 1) begin
            bad++; $display("FAIL flush_pad_writes got=%0d required=1", got_addr.size());
        end else begin
            total++;
            if (got_addr[0] !== 9'd32 || got_dat[0][511:160] !== '0 || got_dat[0] !== exp_dat[0]) begin
                bad++; $display("FAIL flush_pad_line addr=%0d data=%h required addr=32 data=%h", got_addr[0], got_dat[0], exp_dat[0]);
            end
        end
        total++;
        if (line_count !== 8'd1) begin bad++; $display("FAIL flush_pad_count got=%0d required=1", line_count); end
`else
        total++;
        if (got_addr.size() != 0 || line_count !== 8'd0) begin
            bad++; $display("FAIL flush_discard writes=%0d cnt=%0d required 0 0", got_addr.size(), line_count);
        end
`endif
    endtask

    task automatic test_restart();
        clear_logs();
        do_start(9'd0);
        send(7, '0, 1'b1);
        do_start(9'd64);
        send(16, 32'h2000, 1'b0);
        total++;
        if (mem_we !== 1'b1) begin bad++; $display("FAIL restart_we got=%b required=1", mem_we); end
        start = 1'b1; base_addr = 9'd128;
        step();
        start = 1'b0;
        send(16, '0, 1'b1);
        step(); step(); step();
        total++;
        if (got_addr.size() != 2) begin
            bad++; $display("FAIL restart_writes got=%0d required=2", got_addr.size());
        end else foreach (exp_addr[i]) begin
            total++;
            if (got_addr[i] !== exp_addr[i] || got_dat[i] !== exp_dat[i]) begin
                bad++; $display("FAIL restart_line%0d addr=%0d required=%0d data_ok=%b", i, got_addr[i], exp_addr[i], got_dat[i] === exp_dat[i]);
            end
        end
        total++;
        if (line_count !== 8'd2) begin bad++; $display("FAIL restart_count got=%0d required=2", line_count); end
    endtask

    task automatic test_async_reset();
        clear_logs();
        do_start(9'd0);
        send(16, '0, 1'b1);
        total++;
        if (mem_we !== 1'b1) begin bad++; $display("FAIL arst_pre_we got=%b required=1", mem_we); end
        #1 rst = 1'b1;
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_oe !== 1'b1) begin
            bad++; $display("FAIL arst_we_drop we=%b oe=%b required we=0 oe=1", mem_we, mem_oe);
        end
        @(negedge clk) rst = 1'b0;
        step();
        total++;
        if (line_count !== 8'd0 || busy !== 1'b0 || got_addr.size() != 0) begin
            bad++; $display("FAIL arst_after cnt=%0d busy=%b writes=%0d required 0 0 0", line_count, busy, got_addr.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            clear_logs();
            do_start(ADDR_W'($urandom_range(0, 511)));
            send($urandom_range(0, 40), '0, 1'b1);
            do_flush(1'($urandom_range(0, 1)));
            wait_done("rand");
            step();
            total++;
            if (got_addr.size() != exp_addr.size()) begin
                bad++; $display("FAIL rand%0d_writes got=%0d required=%0d", r, got_addr.size(), exp_addr.size());
            end else foreach (exp_addr[i]) begin
                total++;
                if (got_addr[i] !== exp_addr[i] || got_dat[i] !== exp_dat[i]) begin
                    bad++; $display("FAIL rand%0d_line%0d addr=%0d required=%0d data_ok=%b", r, i, got_addr[i], exp_addr[i], got_dat[i] === exp_dat[i]);
                end
            end
            total++;
            if (line_count !== 8'(m_cnt)) begin bad++; $display("FAIL rand%0d_count got=%0d required=%0d", r, line_count, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_two_lines();
        test_wrap();
        test_flush();
        test_restart();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
